// File: rtl/uart_gesture_reporter.sv
// Gesture event reporter: queues classifier events and prints one ASCII line
// per event over a UART. Define UART_REPORT_CONF_EN to append " HH" confidence.
// Ports: clk, rst_n (sync, active-low); gesture_class/valid/confidence in;
// uart_tx line out; fifo_level, overflow, drop_count, busy status out.

module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;

  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic [8:0]    sh_q;
  logic          tx_q;
  logic          busy_q;

  // bit_q: 0 = start bit, 1..8 = data LSB first, 9 = stop bit
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '1;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else if (!busy_q) begin
      if (valid_i) begin
        tx_q   <= 1'b0;
        sh_q   <= {1'b1, data_i};
        cnt_q  <= '0;
        bit_q  <= '0;
        busy_q <= 1'b1;
      end
    end else if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
      cnt_q <= '0;
      if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
      end else begin
        tx_q  <= sh_q[0];
        sh_q  <= {1'b1, sh_q[8:1]};
        bit_q <= bit_q + 4'd1;
      end
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
endmodule

module uart_gesture_reporter #(
  parameter int CLK_FREQ_HZ     = 12_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 4,
  parameter int SUPPRESS_REPEAT = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  gesture_class,
  input  logic                        gesture_valid,
  input  logic [7:0]                  gesture_confidence,
  output logic                        uart_tx,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic [7:0]                  drop_count,
  output logic                        busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef UART_REPORT_CONF_EN
  localparam int         EW    = 10;
  localparam logic [3:0] EXTRA = 4'd3;
`else
  localparam int         EW    = 2;
  localparam logic [3:0] EXTRA = 4'd0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_ACK} state_t;

  function automatic logic [3:0] name_len(input logic [1:0] c);
    logic [3:0] n;
    unique case (c)
      2'd0:    n = 4'd2;
      2'd1:    n = 4'd4;
      2'd2:    n = 4'd4;
      default: n = 4'd5;
    endcase
    return n;
  endfunction

`ifdef UART_REPORT_CONF_EN
  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] msg_byte(input logic [1:0] c,
                                          input logic [7:0] k,
                                          input logic [3:0] i);
`else
  function automatic logic [7:0] msg_byte(input logic [1:0] c,
                                          input logic [3:0] i);
`endif
    logic [39:0] nm;
    logic [39:0] t;
    logic [3:0]  off;
    logic [7:0]  b;
    unique case (c)
      2'd0:    nm = 40'h55_50_00_00_00;
      2'd1:    nm = 40'h44_4F_57_4E_00;
      2'd2:    nm = 40'h4C_45_46_54_00;
      default: nm = 40'h52_49_47_48_54;
    endcase
    t   = nm << {i[2:0], 3'b000};
    off = i - name_len(c);
    if (i < name_len(c)) begin
      b = t[39:32];
    end else begin
`ifdef UART_REPORT_CONF_EN
      unique case (off)
        4'd0:    b = 8'h20;
        4'd1:    b = hex_ch(k[7:4]);
        4'd2:    b = hex_ch(k[3:0]);
        4'd3:    b = 8'h0D;
        default: b = 8'h0A;
      endcase
`else
      b = (off == 4'd0) ? 8'h0D : 8'h0A;
`endif
    end
    return b;
  endfunction

  // event FIFO
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q;
  logic          ovf_q;
  logic [7:0]    drop_q;
  logic [1:0]    last_q;
  logic          last_v_q;
  logic [EW-1:0] wr_entry, head;
  logic          full, filt, push, drop, pop;

`ifdef UART_REPORT_CONF_EN
  assign wr_entry = {gesture_confidence, gesture_class};
`else
  logic unused_conf;
  assign unused_conf = ^gesture_confidence;
  assign wr_entry    = gesture_class;
`endif

  assign head = mem_q[rd_ptr_q];
  assign full = (count_q == LW'(FIFO_DEPTH));
  assign filt = (SUPPRESS_REPEAT != 0) && last_v_q &&
                (gesture_class == last_q);
  assign push = gesture_valid && !filt && !full;
  assign drop = gesture_valid && !filt && full;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      last_q   <= '0;
      last_v_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        last_q   <= gesture_class;
        last_v_q <= 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + LW'(push) - LW'(pop);
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  // line FSM
  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] cls_q, cls_d;
  logic [7:0] txd_q, txd_d;
  logic [3:0] last_idx;
  logic       tx_valid, tx_busy;
`ifdef UART_REPORT_CONF_EN
  logic [7:0] conf_q, conf_d;
`endif

  assign last_idx = name_len(cls_q) + EXTRA + 4'd1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cls_d    = cls_q;
    txd_d    = txd_q;
    tx_valid = 1'b0;
    pop      = 1'b0;
`ifdef UART_REPORT_CONF_EN
    conf_d   = conf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          cls_d   = head[1:0];
`ifdef UART_REPORT_CONF_EN
          conf_d  = head[9:2];
`endif
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef UART_REPORT_CONF_EN
        txd_d   = msg_byte(cls_q, conf_q, idx_q);
`else
        txd_d   = msg_byte(cls_q, idx_q);
`endif
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_valid = 1'b1;
          state_d  = S_ACK;
        end
      end
      S_ACK: begin
        if (tx_busy) begin
          if (idx_q == last_idx) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cls_q   <= '0;
      txd_q   <= '0;
`ifdef UART_REPORT_CONF_EN
      conf_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cls_q   <= cls_d;
      txd_q   <= txd_d;
`ifdef UART_REPORT_CONF_EN
      conf_q  <= conf_d;
`endif
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .valid_i(tx_valid),
    .data_i (txd_q),
    .tx_o   (uart_tx),
    .busy_o (tx_busy)
  );

  assign fifo_level = count_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
endmodule

// File: tb/tb_uart_gesture_reporter.sv
// Bench for uart_gesture_reporter: three instances (depth 4, depth 2,
// repeat suppression) at 10 clocks per bit, decoding the serial lines.

module tb_uart_gesture_reporter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn [3];
  logic       gv [3];
  logic [1:0] gc [3];
  logic [7:0] gk [3];

  logic       utA, utB, utC, ovA, ovB, ovC, bsA, bsB, bsC;
  logic [7:0] dcA, dcB, dcC;
  logic [2:0] lvlA, lvlC;
  logic [1:0] lvlB;

  logic       ut [3], ovf [3], bsy [3], tv [3], tb [3];
  logic [7:0] dc [3];

  uart_gesture_reporter #(
    .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000),
    .FIFO_DEPTH(4), .SUPPRESS_REPEAT(0)
  ) dA (
    .clk(clk), .rst_n(rn[0]), .gesture_class(gc[0]),
    .gesture_valid(gv[0]), .gesture_confidence(gk[0]),
    .uart_tx(utA), .fifo_level(lvlA), .overflow(ovA),
    .drop_count(dcA), .busy(bsA)
  );

  uart_gesture_reporter #(
    .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000),
    .FIFO_DEPTH(2), .SUPPRESS_REPEAT(0)
  ) dB (
    .clk(clk), .rst_n(rn[1]), .gesture_class(gc[1]),
    .gesture_valid(gv[1]), .gesture_confidence(gk[1]),
    .uart_tx(utB), .fifo_level(lvlB), .overflow(ovB),
    .drop_count(dcB), .busy(bsB)
  );

  uart_gesture_reporter #(
    .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000),
    .FIFO_DEPTH(4), .SUPPRESS_REPEAT(1)
  ) dC (
    .clk(clk), .rst_n(rn[2]), .gesture_class(gc[2]),
    .gesture_valid(gv[2]), .gesture_confidence(gk[2]),
    .uart_tx(utC), .fifo_level(lvlC), .overflow(ovC),
    .drop_count(dcC), .busy(bsC)
  );

  always_comb begin
    ut[0] = utA; ut[1] = utB; ut[2] = utC;
    ovf[0] = ovA; ovf[1] = ovB; ovf[2] = ovC;
    bsy[0] = bsA; bsy[1] = bsB; bsy[2] = bsC;
    dc[0] = dcA; dc[1] = dcB; dc[2] = dcC;
    tv[0] = dA.tx_valid; tv[1] = dB.tx_valid; tv[2] = dC.tx_valid;
    tb[0] = dA.tx_busy; tb[1] = dB.tx_busy; tb[2] = dC.tx_busy;
  end

  function automatic int lvl(input int i);
    if (i == 0) return int'(lvlA);
    if (i == 1) return int'(lvlB);
    return int'(lvlC);
  endfunction

  // serial decoders, sampled on the rising edge (pre-update values)
  logic         act [3];
  int           cnt [3];
  logic [7:0]   sh [3];
  logic [255:0] rxv [3];
  int           rxn [3];
  int           ferr = 0;
  initial for (int i = 0; i < 3; i++) begin
    act[i] = 1'b0; cnt[i] = 0; sh[i] = '0; rxv[i] = '0; rxn[i] = 0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rn[i]) begin
        act[i] = 1'b0;
      end else if (!act[i]) begin
        if (!ut[i]) begin
          act[i] = 1'b1;
          cnt[i] = 0;
        end
      end else begin
        cnt[i]++;
        if (cnt[i] >= 14 && cnt[i] <= 84 && (cnt[i] - 14) % 10 == 0)
          sh[i] = {ut[i], sh[i][7:1]};
        if (cnt[i] == 94) begin
          act[i] = 1'b0;
          if (ut[i]) begin
            rxv[i] = {rxv[i][247:0], sh[i]};
            rxn[i]++;
          end else begin
            ferr++;
          end
        end
      end
    end
  end

  // tx_valid handshake monitor
  logic pv [3];
  int   viol = 0;
  initial for (int i = 0; i < 3; i++) pv[i] = 1'b0;
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (tv[i] && tb[i]) viol++;
      if (tv[i] && pv[i]) viol++;
      pv[i] = tv[i];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic chk_line(input int i, input int n0,
                          input logic [255:0] e, input int len,
                          input string nm);
    logic [255:0] mask;
    mask = (256'd1 << (8 * len)) - 256'd1;
    chk({nm, "_nbytes"}, rxn[i] - n0, len);
    checks++;
    if ((rxv[i] & mask) !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, rxv[i] & mask, e);
    end
  endtask

  task automatic strobe(input int i, input logic [1:0] c,
                        input logic [7:0] k);
    gv[i] = 1'b1;
    gc[i] = c;
    gk[i] = k;
    @(negedge clk);
    gv[i] = 1'b0;
  endtask

  // busy drops when the last byte is handed over; let it finish on the wire
  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    while (bsy[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(n < budget), 1);
    repeat (120) @(negedge clk);
  endtask

  typedef struct packed {
    logic [1:0]   cls;
    logic [7:0]   conf;
    logic [255:0] txt;
    logic [7:0]   len;
  } vec_t;

  initial begin
    vec_t         tbl [4];
    logic [255:0] exp_v;
    int           n0, seen, t, lows;

`ifdef UART_REPORT_CONF_EN
    tbl[0] = '{2'd3, 8'hA7, 256'("RIGHT A7\015\012"), 8'd10};
    tbl[1] = '{2'd0, 8'h05, 256'("UP 05\015\012"), 8'd7};
    tbl[2] = '{2'd1, 8'hFF, 256'("DOWN FF\015\012"), 8'd9};
    tbl[3] = '{2'd2, 8'h3C, 256'("LEFT 3C\015\012"), 8'd9};
`else
    tbl[0] = '{2'd3, 8'hA7, 256'("RIGHT\015\012"), 8'd7};
    tbl[1] = '{2'd0, 8'h05, 256'("UP\015\012"), 8'd4};
    tbl[2] = '{2'd1, 8'hFF, 256'("DOWN\015\012"), 8'd6};
    tbl[3] = '{2'd2, 8'h3C, 256'("LEFT\015\012"), 8'd6};
`endif

    for (int i = 0; i < 3; i++) begin
      rn[i] = 1'b0; gv[i] = 1'b0; gc[i] = '0; gk[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_uart_tx", int'(ut[i]), 1);
      chk("rst_level", lvl(i), 0);
      chk("rst_overflow", int'(ovf[i]), 0);
      chk("rst_drops", int'(dc[i]), 0);
      chk("rst_busy", int'(bsy[i]), 0);
    end
    for (int i = 0; i < 3; i++) rn[i] = 1'b1;
    repeat (2) @(negedge clk);

    // single events, one per class
    for (int v = 0; v < 4; v++) begin
      n0 = rxn[0];
      strobe(0, tbl[v].cls, tbl[v].conf);
      chk("push_level", int'(lvlA), 1);
      chk("push_busy", int'(bsA), 1);
      seen = 0;
      for (int k = 0; k < 5; k++) begin
        if (!utA) seen = 1;
        @(negedge clk);
      end
      chk("start_latency", seen, 1);
      wait_idle(0, 3000);
      chk("post_level", int'(lvlA), 0);
      chk("post_busy", int'(bsA), 0);
      chk_line(0, n0, tbl[v].txt, int'(tbl[v].len), "vec_line");
    end

    // three events on consecutive cycles
    n0 = rxn[0];
    strobe(0, 2'd0, 8'h11);
    strobe(0, 2'd1, 8'h22);
    strobe(0, 2'd2, 8'h9B);
    wait_idle(0, 5000);
`ifdef UART_REPORT_CONF_EN
    exp_v = 256'("UP 11\015\012DOWN 22\015\012LEFT 9B\015\012");
    chk_line(0, n0, exp_v, 25, "burst_lines");
`else
    exp_v = 256'("UP\015\012DOWN\015\012LEFT\015\012");
    chk_line(0, n0, exp_v, 16, "burst_lines");
`endif
    chk("burst_overflow", int'(ovA), 0);
    chk("burst_drops", int'(dcA), 0);

    // depth-2 overflow: six strobes back to back
    n0 = rxn[1];
    strobe(1, 2'd1, 8'h5A);
    strobe(1, 2'd2, 8'h5A);
    strobe(1, 2'd3, 8'h5A);
    strobe(1, 2'd0, 8'h5A);
    strobe(1, 2'd1, 8'h5A);
    strobe(1, 2'd2, 8'h5A);
    chk("ovf_level", int'(lvlB), 2);
    chk("ovf_drops", int'(dcB), 3);
    chk("ovf_flag", int'(ovB), 1);
    wait_idle(1, 5000);
`ifdef UART_REPORT_CONF_EN
    exp_v = 256'("DOWN 5A\015\012LEFT 5A\015\012RIGHT 5A\015\012");
    chk_line(1, n0, exp_v, 28, "ovf_lines");
`else
    exp_v = 256'("DOWN\015\012LEFT\015\012RIGHT\015\012");
    chk_line(1, n0, exp_v, 19, "ovf_lines");
`endif
    chk("ovf_drops_hold", int'(dcB), 3);

    // repeat suppression
    n0 = rxn[2];
    strobe(2, 2'd2, 8'h0F);
    repeat (2000) @(negedge clk);
    strobe(2, 2'd2, 8'h0F);
    chk("filtered_level", int'(lvlC), 0);
    repeat (2000) @(negedge clk);
    strobe(2, 2'd0, 8'h0F);
    repeat (2000) @(negedge clk);
    strobe(2, 2'd0, 8'h0F);
    repeat (2000) @(negedge clk);
    strobe(2, 2'd2, 8'h0F);
    wait_idle(2, 3000);
`ifdef UART_REPORT_CONF_EN
    exp_v = 256'("LEFT 0F\015\012UP 0F\015\012LEFT 0F\015\012");
    chk_line(2, n0, exp_v, 25, "supp_lines");
`else
    exp_v = 256'("LEFT\015\012UP\015\012LEFT\015\012");
    chk_line(2, n0, exp_v, 16, "supp_lines");
`endif
    chk("supp_drops", int'(dcC), 0);

    // reset during the third byte of DOWN with two events queued
    n0 = rxn[1];
    strobe(1, 2'd1, 8'h5A);
    strobe(1, 2'd0, 8'h5A);
    strobe(1, 2'd3, 8'h5A);
    chk("mid_level", int'(lvlB), 2);
    t = 0;
    while (rxn[1] - n0 < 2 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("mid_timeout", int'(t < 1000), 1);
    repeat (50) @(negedge clk);
    chk("mid_line_low", int'(utB), 0);
    rn[1] = 1'b0;
    @(negedge clk);
    rn[1] = 1'b1;
    chk("mrst_uart_tx", int'(utB), 1);
    chk("mrst_level", int'(lvlB), 0);
    chk("mrst_overflow", int'(ovB), 0);
    chk("mrst_drops", int'(dcB), 0);
    chk("mrst_busy", int'(bsB), 0);
    n0 = rxn[1];
    lows = 0;
    repeat (1500) begin
      @(negedge clk);
      if (!utB) lows++;
    end
    chk("mrst_line_quiet", lows, 0);
    chk("mrst_no_bytes", rxn[1] - n0, 0);

    chk("handshake_violations", viol, 0);
    chk("framing_errors", ferr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_gesture_reporter.md
# uart_gesture_reporter

Parametrised UART reporter for gesture classification results, sitting between the gesture classifier and the board UART pin. Gesture events are buffered in a FIFO so bursts are not lost while a line is transmitted. Each event is rendered as an ASCII line (name, optional confidence in hex, CR LF) and driven out through the existing `uart_tx` serializer. Drops and repeats are handled explicitly.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 12_000_000: system clock frequency.
- `BAUD_RATE`, 115200: line rate; `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE` is passed to `uart_tx`.
- `FIFO_DEPTH`, 4: event queue depth; must be a power of two, ≥2.
- `SUPPRESS_REPEAT`, 0: if 1, an event whose class equals the last *accepted* class is discarded (not counted as a drop).

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous active-low reset.
- `gesture_class` in 2: 0=UP, 1=DOWN, 2=LEFT, 3=RIGHT.
- `gesture_valid` in 1: single-cycle event strobe.
- `gesture_confidence` in 8: confidence, sampled with `gesture_valid`.
- `uart_tx` out 1: serial line, idle high.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: queued events, excluding the one being sent.
- `overflow` out 1: sticky, set on first dropped event.
- `drop_count` out 8: dropped events, saturating at 255.
- `busy` out 1: high while a line is in progress or the FIFO is non-empty.

## Operation
- Push: on `gesture_valid`, {class, confidence} is written unless filtered or the FIFO is full.
  - Filtered (`SUPPRESS_REPEAT`=1 and class == last accepted class): ignored.
  - Full: the event is dropped, `overflow` is set, and `drop_count` increments (saturating).
  - Fullness is evaluated at the start of the cycle. A push while full is dropped even if a pop occurs in the same cycle.
  - Last-accepted class resets to "none", so the first event is never filtered.
- Message format: name bytes, then (if `UART_REPORT_CONF_EN`) a space and two uppercase hex digits of confidence, MSB nibble first, then 0x0D 0x0A.
  - Names: UP, DOWN, LEFT, RIGHT.
  - Lengths without confidence: 4/6/6/7 bytes. With confidence: 7/9/9/10 bytes.
  - Byte index is 4 bits wide. Bytes come from a combinational function of (class, confidence, index).
- FSM states:
  - S_IDLE: if the FIFO is non-empty, pop the head into the line registers, set index to 0, and go to S_LOAD.
  - S_LOAD: compute the byte at the current index into `tx_data`, then go to S_SEND.
  - S_SEND: when `uart_tx` busy is low, pulse `tx_valid` for 1 cycle and go to S_ACK.
  - S_ACK: wait for `uart_tx` busy high. Then, if index == length-1, go to S_IDLE; else increment the index and go to S_LOAD.
- `tx_valid` is never asserted in two consecutive cycles, and never while `uart_tx` busy is high.
- Reset mid-line: the FSM goes to S_IDLE, the FIFO is emptied, and `uart_tx` is reset, so the line returns high on the next cycle. The partial byte is abandoned.

## Timing
- Reset values:
  - `uart_tx`=1, `fifo_level`=0, `overflow`=0, `drop_count`=0, `busy`=0.
  - Internally: `tx_valid`=0 and state S_IDLE.
- Push latency: `fifo_level` increments 1 cycle after an accepted `gesture_valid`.
- Start latency: `gesture_valid` into an empty idle block causes the `uart_tx` start bit to fall within 5 cycles of the strobe.
- Inter-byte gap: no more than 4 clocks of idle-high between the stop bit of byte n and the start bit of byte n+1.
- A back-to-back event arriving during a line is sent immediately after the current line's final byte, with the same ≤5-cycle gap.
- `busy` deasserts in the cycle S_IDLE is entered with the FIFO empty; the final stop bit may still be on the wire at that point.

## Configuration
- `UART_REPORT_CONF_EN` defined: confidence suffix " HH" is included, and the FIFO entry is 10 bits wide.
- Not defined: name plus CR LF only. The confidence input is unused, and the FIFO entry is 2 bits wide.

## Test plan
Benches use CLK_FREQ_HZ=1_000_000 and BAUD_RATE=100_000 (10 clocks per bit).
- Single event, class 3, confidence 0xA7, macro on -> decoded bytes "RIGHT A7\r\n" (10 bytes); `busy` returns to 0; `fifo_level` stays 0 after the pop.
- Macro off, events classes 0,1,2 on 3 consecutive cycles, FIFO_DEPTH=4 -> "UP\r\nDOWN\r\nLEFT\r\n" in order; `overflow`=0.
- FIFO_DEPTH=2, 6 strobes 1 cycle apart -> first event in flight, 2 queued, 3 dropped; `drop_count`=3 and `overflow`=1; exactly 3 lines are output.
- SUPPRESS_REPEAT=1, classes 2,2,0,0,2 spaced 2000 cycles apart -> lines LEFT, UP, LEFT; `drop_count`=0.
- Assert `rst_n`=0 for 1 cycle during the 3rd byte of "DOWN" with 2 events queued -> `uart_tx`=1 the next cycle; all counters and flags are 0; no further bytes are sent.
- Protocol check across all scenarios: a `tx_valid` pulse occurs only when `uart_tx` busy is 0, and never in 2 consecutive cycles.
